multicycle_controller: RTL and testbench

- Sequencing controller for the multicycle ARM-subset core; replaces the single-cycle decode path when the datapath shares one memory and one ALU across cycles.
- Decodes the registered instruction fields, evaluates condition codes against an internal NZCV register, and steps a Moore FSM.
- Drives every datapath mux, enable and write strobe: PC, IR, register file, memory, ALU.

---
 rtl/multicycle_controller_pkg.sv | 58 +++++
 rtl/multicycle_controller_cond_check.sv | 37 +++
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// datapath mux codes, ALU commands and condition-code constants.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing command field, Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Condition evaluation: instruction Cond field against the stored NZCV flags.
module multicycle_controller_cond_check
    import multicycle_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic neg, zero, carry, ovf, ge;

    assign {neg, zero, carry, ovf} = flags;
    assign ge = (neg == ovf);

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = zero;
            COND_NE: cond_ex = ~zero;
            COND_CS: cond_ex = carry;
            COND_CC: cond_ex = ~carry;
            COND_MI: cond_ex = neg;
            COND_PL: cond_ex = ~neg;
            COND_VS: cond_ex = ovf;
            COND_VC: cond_ex = ~ovf;
            COND_HI: cond_ex = carry & ~zero;
            COND_LS: cond_ex = ~carry | zero;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~zero & ge;
            COND_LE: cond_ex = zero | ~ge;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM, ALU decode and conditional write gating for the
// multicycle core. Define CU_CMP_EN to decode Funct[4:1]=1010 as CMP.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags
);

    if (STATE_W != $bits(state_t)) begin : g_bad_state_w
        $error("STATE_W must match the width of state_t");
    end

    state_t     state, state_next;
    logic       next_pc, branch, reg_w, mem_w, ir_write, alu_op;
    logic [1:0] cmd_ctl, cmd_flag_w, flag_w;
    logic       cmd_no_write, no_write;
    logic       cond_ex, cond_ex_hold, cond_ex_eff, pcs;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FETCH;
            Flags        <= 4'b0000;
            cond_ex_hold <= 1'b0;
        end else begin
            state <= state_next;
            if (alu_op) begin
                cond_ex_hold <= cond_ex;
                if (cond_ex) begin
                    if (flag_w[1]) Flags[3:2] <= ALUFlags[3:2];
                    if (flag_w[0]) Flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        alu_op     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECUTER: begin
                alu_op     = 1'b1;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                alu_op     = 1'b1;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        cmd_ctl      = ALU_ADD;
        cmd_flag_w   = 2'b00;
        cmd_no_write = 1'b0;
        case (Funct[4:1])
            CMD_ADD: cmd_flag_w = Funct[0] ? 2'b11 : 2'b00;
            CMD_SUB: begin
                cmd_ctl    = ALU_SUB;
                cmd_flag_w = Funct[0] ? 2'b11 : 2'b00;
            end
            CMD_AND: begin
                cmd_ctl    = ALU_AND;
                cmd_flag_w = Funct[0] ? 2'b10 : 2'b00;
            end
            CMD_ORR: begin
                cmd_ctl    = ALU_ORR;
                cmd_flag_w = Funct[0] ? 2'b10 : 2'b00;
            end
`ifdef CU_CMP_EN
            CMD_CMP: begin
                cmd_ctl      = ALU_SUB;
                cmd_flag_w   = 2'b11;
                cmd_no_write = 1'b1;
            end
`endif
            default: cmd_no_write = 1'b1;
        endcase
    end

    assign ALUControl = alu_op ? cmd_ctl : ALU_ADD;
    assign flag_w     = alu_op ? cmd_flag_w : 2'b00;
    // Funct only means a DP command for Op=00; loads/stores reuse those bits.
    assign no_write   = (Op == OP_DP) & cmd_no_write;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM) & ~Funct[0], Op == OP_BR};

    multicycle_controller_cond_check u_cond_check (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (cond_ex)
    );

    // ALUWB sees flags already updated by its own execute cycle, so it uses
    // the verdict captured before that update.
    assign cond_ex_eff = (state == S_ALUWB) ? cond_ex_hold : cond_ex;
    assign pcs         = branch | (reg_w & (Rd == 4'd15));

    assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex_eff));
    assign RegWrite = ~reset & reg_w & cond_ex_eff & ~no_write;
    assign MemWrite = ~reset & mem_w & cond_ex_eff;
    assign IRWrite  = ~reset & ir_write;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions plus
// random ones, checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags, Flags;
    logic [1:0] Op, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [5:0] Funct;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                  P_EXEC, P_ALUWB, P_BRANCH} phase_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] m_flags  = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {alu_control, flag_w, no_write} for a data-processing Funct.
    function automatic logic [4:0] alu_model(input logic [5:0] f);
        logic s;
        s = f[0];
        case (f[4:1])
            4'd4:  return {2'd0, s ? 2'b11 : 2'b00, 1'b0};
            4'd2:  return {2'd1, s ? 2'b11 : 2'b00, 1'b0};
            4'd0:  return {2'd2, s ? 2'b10 : 2'b00, 1'b0};
            4'd12: return {2'd3, s ? 2'b10 : 2'b00, 1'b0};
`ifdef CU_CMP_EN
            4'd10: return {2'd1, 2'b11, 1'b1};
`endif
            default: return {2'd0, 2'b00, 1'b1};
        endcase
    endfunction

    // Packed {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,ALUControl}
    function automatic logic [15:0] expect_outs(input phase_t ph, input logic [1:0] op,
                                                input logic [5:0] f, input logic [3:0] rd,
                                                input logic ok);
        logic       pcw = 0, adr = 0, memw = 0, irw = 0, regw = 0, srca = 0;
        logic [1:0] res = 0, srcb = 0, ctl = 0;
        logic [4:0] am;
        am = alu_model(f);
        case (ph)
            P_FETCH:    begin pcw = 1; irw = 1; srca = 1; srcb = 2; res = 2; end
            P_DECODE:   begin srca = 1; srcb = 2; res = 2; end
            P_MEMADR:   srcb = 1;
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin res = 1; regw = ok; pcw = ok && rd == 15; end
            P_MEMWRITE: begin adr = 1; memw = ok; end
            P_EXEC:     begin srcb = f[5] ? 2'd1 : 2'd0; ctl = am[4:3]; end
            P_ALUWB:    begin regw = ok && !am[0]; pcw = ok && rd == 15; end
            P_BRANCH:   begin srcb = 1; res = 2; pcw = ok; end
            default:    ;
        endcase
        return {pcw, adr, memw, irw, regw, res, srca, srcb, op,
                (op == 2'b01) && !f[0], op == 2'b10, ctl};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegSrc, ALUControl};
    endfunction

    // Called while the DUT sits in FETCH; returns with the DUT in the next FETCH.
    task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
        phase_t     ph[$];
        logic       ok;
        logic [4:0] am;
        Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        case (op)
            2'b01: begin
                ph.push_back(P_MEMADR);
                if (f[0]) begin ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
                else ph.push_back(P_MEMWRITE);
            end
            2'b00: begin ph.push_back(P_EXEC); ph.push_back(P_ALUWB); end
            2'b10: ph.push_back(P_BRANCH);
            default: ;
        endcase
        ok = cond_holds(c, m_flags);
        am = alu_model(f);
        #1;
        foreach (ph[i]) begin
            check($sformatf("%s.c%0d.%s.outs", tag, i, ph[i].name()), 32'(dut_outs()),
                  32'(expect_outs(ph[i], op, f, rd, ok)));
            check($sformatf("%s.c%0d.flags", tag, i), 32'(Flags), 32'(m_flags));
            if (ph[i] == P_EXEC && ok) begin
                if (am[2]) m_flags[3:2] = af[3:2];
                if (am[1]) m_flags[1:0] = af[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] cmds [5];
        logic [5:0] rf;
        cmds[0] = 4'd0; cmds[1] = 4'd2; cmds[2] = 4'd4; cmds[3] = 4'd12; cmds[4] = 4'd10;

        reset = 1'b1; Cond = 4'he; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        @(posedge clk); #1;
        check("reset.strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk); #1;
        check("reset.flags", 32'(Flags), 32'd0);
        reset = 1'b0;
        #1;
        check("reset.fetch", 32'(dut_outs()), 32'(expect_outs(P_FETCH, 2'b00, 6'd0, 4'd0, 1'b1)));

        run_instr("adds",     4'he, 2'b00, 6'b001001, 4'd3,  4'b0100);
        run_instr("ldr",      4'he, 2'b01, 6'b011001, 4'd5,  4'b0000);
        run_instr("bne_z1",   4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000);
        run_instr("adds_z0",  4'he, 2'b00, 6'b001001, 4'd2,  4'b0000);
        run_instr("bne_z0",   4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000);
        run_instr("streq_z0", 4'h0, 2'b01, 6'b011000, 4'd7,  4'b0000);
        run_instr("adds_z1",  4'he, 2'b00, 6'b001001, 4'd2,  4'b0100);
        run_instr("streq_z1", 4'h0, 2'b01, 6'b011000, 4'd7,  4'b0000);
        run_instr("cmp",      4'he, 2'b00, 6'b010101, 4'd0,  4'b0110);
        run_instr("subs_imm", 4'he, 2'b00, 6'b100101, 4'd15, 4'b1011);
        run_instr("ldr_pc",   4'he, 2'b01, 6'b011001, 4'd15, 4'b0000);
        run_instr("op11",     4'he, 2'b11, 6'b111111, 4'd1,  4'b1111);
        run_instr("nv",       4'hf, 2'b00, 6'b001001, 4'd1,  4'b1111);

        for (int k = 0; k < 60; k++) begin
            rf = 6'($urandom);
            if ($urandom_range(0, 3) != 0) rf[4:1] = cmds[$urandom_range(0, 4)];
            run_instr($sformatf("rnd%0d", k), 4'($urandom), 2'($urandom_range(0, 3)),
                      rf, 4'($urandom), 4'($urandom));
        end

        // Load all flags, then abort an ADDS in EXECUTER with a 2-cycle reset.
        run_instr("adds_all", 4'he, 2'b00, 6'b001001, 4'd1, 4'b1111);
        Cond = 4'he; Op = 2'b00; Funct = 6'b001001; Rd = 4'd1; ALUFlags = 4'b0101;
        @(posedge clk); @(posedge clk); #1;
        check("midexec.alu", 32'(ALUControl), 32'd0);
        reset = 1'b1;
        #1;
        check("midreset.strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        m_flags = 4'b0000;
        #1;
        check("midreset.flags", 32'(Flags), 32'd0);
        check("midreset.fetch", 32'(dut_outs()),
              32'(expect_outs(P_FETCH, 2'b00, 6'b001001, 4'd1, 1'b1)));
        run_instr("post_reset", 4'h0, 2'b10, 6'd0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
